dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: 512-byte data memory behind the core load/store port.
// SB/SH/SW stores, LB/LH/LW/LBU/LHU loads, 1-cycle registered read.
module dmem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              misaligned,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-3:0] idx;
  logic [1:0]        off;
  logic              st_ok;
  logic              ld_ok;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] shft;
  logic [DATA_W-1:0] ld_val;
  logic              sx;
  logic              do_wr;
  logic              do_rd;
  logic              bad;

  assign idx  = addr[ADDR_W-1:2];
  assign off  = addr[1:0];
  assign word = mem[idx];
  assign shft = word >> {off, 3'b000};
  assign sx   = ~funct3[2];

  // Decode size/sign into legality, lane enables and lane-replicated data
  always_comb begin
    st_ok = 1'b0;
    ld_ok = 1'b0;
    be    = 4'b0000;
    wdata = wr_data;
    case (funct3)
      3'b000: begin
        st_ok = 1'b1;
        ld_ok = 1'b1;
        be    = 4'b0001 << off;
        wdata = {4{wr_data[7:0]}};
      end
      3'b001: begin
        st_ok = ~off[0];
        ld_ok = ~off[0];
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wr_data[15:0]}};
      end
      3'b010: begin
        st_ok = (off == 2'b00);
        ld_ok = (off == 2'b00);
        be    = 4'b1111;
      end
      3'b100: ld_ok = 1'b1;
      3'b101: ld_ok = ~off[0];
      default: ;
    endcase
  end

  // Shift selected lane to bit 0 and sign/zero-extend
  always_comb begin
    case (funct3[1:0])
      2'b00:   ld_val = {{24{sx & shft[7]}}, shft[7:0]};
      2'b01:   ld_val = {{16{sx & shft[15]}}, shft[15:0]};
      default: ld_val = shft;
    endcase
  end

  assign do_wr = wr & ~rd & st_ok;
  assign do_rd = rd & ~wr & ld_ok;
  assign bad   = (wr | rd) & ~(do_wr | do_rd);

  // Byte-lane store; reset suppresses any store in the same cycle
  always_ff @(posedge clk) begin
    if (!reset && do_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Load result, error pulses and saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      misaligned <= 1'b0;
      err_sticky <= 1'b0;
      wr_count   <= '0;
      rd_count   <= '0;
    end else begin
      rd_valid   <= 1'b0;
      misaligned <= 1'b0;
      if (bad) begin
        misaligned <= 1'b1;
        err_sticky <= 1'b1;
        if (rd && !wr) rd_data <= '0;
      end
      if (do_wr && wr_count != '1) wr_count <= wr_count + CNT_W'(1);
      if (do_rd) begin
        rd_data  <= ld_val;
        rd_valid <= 1'b1;
        if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed test-plan scenarios plus random traffic
// checked against a byte-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        misaligned;
  logic        err_sticky;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int n_checks = 0;
  int n_err = 0;

  logic [7:0]  mm [512];
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_mis;
  logic        m_err;
  int          m_wc;
  int          m_rc;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .rd         (rd),
    .addr       (addr),
    .wr_data    (wr_data),
    .funct3     (funct3),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .misaligned (misaligned),
    .err_sticky (err_sticky),
    .wr_count   (wr_count),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a flat byte array, access legality from
  // size/alignment arithmetic.
  task automatic model(input logic w, input logic r,
                       input logic [8:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic rs);
    int sz;
    bit ok_st;
    bit ok_ld;
    bit fail;
    logic [31:0] v;
    sz = 1 << f[1:0];
    ok_st = (f <= 3'd2) && (int'(a) % sz == 0);
    ok_ld = (f == 0 || f == 1 || f == 2 || f == 4 || f == 5)
            && (int'(a) % sz == 0);
    fail = 1'b0;
    if (rs) begin
      m_data = 0; m_valid = 0; m_mis = 0; m_err = 0;
      m_wc = 0; m_rc = 0;
      return;
    end
    m_valid = 0;
    m_mis = 0;
    if (w && r) begin
      fail = 1'b1;
    end else if (w) begin
      if (ok_st) begin
        for (int i = 0; i < sz; i++) mm[(int'(a) + i) % 512] = d[8*i +: 8];
        if (m_wc < 65535) m_wc++;
      end else fail = 1'b1;
    end else if (r) begin
      if (ok_ld) begin
        v = 0;
        for (int i = 0; i < sz; i++)
          v = v | (32'(mm[(int'(a) + i) % 512]) << (8*i));
        if (!f[2] && sz < 4 && v[8*sz-1])
          v = v | ~((32'h1 << (8*sz)) - 32'h1);
        m_data = v;
        m_valid = 1;
        if (m_rc < 65535) m_rc++;
      end else begin
        fail = 1'b1;
        m_data = 0;
      end
    end
    if (fail) begin
      m_mis = 1;
      m_err = 1;
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [8:0] a,
                      input logic [31:0] d, input logic [2:0] f,
                      input logic rs);
    @(negedge clk);
    wr = w; rd = r; addr = a; wr_data = d; funct3 = f; reset = rs;
    @(posedge clk);
    model(w, r, a, d, f, rs);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    n_checks++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset rd_data got=%h exp=0", rd_data); end
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset rd_valid got=%b exp=0", rd_valid); end
    n_checks++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL reset misaligned got=%b exp=0", misaligned); end
    n_checks++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL reset err_sticky got=%b exp=0", err_sticky); end
    n_checks++; if (wr_count !== 16'h0) begin n_err++; $display("FAIL reset wr_count got=%0d exp=0", wr_count); end
    n_checks++; if (rd_count !== 16'h0) begin n_err++; $display("FAIL reset rd_count got=%0d exp=0", rd_count); end
  endtask

  task automatic test_sw_lw();
    step(1, 0, 9'h010, 32'hDEADBEEF, F_W, 0);
    step(0, 1, 9'h010, 0, F_W, 0);
    n_checks++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL sw_lw valid got=%b exp=1", rd_valid); end
    n_checks++; if (rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_lw data got=%h exp=deadbeef", rd_data); end
    n_checks++; if (wr_count !== 16'd1) begin n_err++; $display("FAIL sw_lw wr_count got=%0d exp=1", wr_count); end
    n_checks++; if (rd_count !== 16'd1) begin n_err++; $display("FAIL sw_lw rd_count got=%0d exp=1", rd_count); end
  endtask

  task automatic test_byte();
    step(1, 0, 9'h013, 32'h000000A5, F_B, 0);
    step(0, 1, 9'h013, 0, F_B, 0);
    n_checks++; if (rd_data !== 32'hFFFFFFA5) begin n_err++; $display("FAIL lb data got=%h exp=ffffffa5", rd_data); end
    step(0, 1, 9'h013, 0, F_BU, 0);
    n_checks++; if (rd_data !== 32'h000000A5) begin n_err++; $display("FAIL lbu data got=%h exp=000000a5", rd_data); end
    step(0, 1, 9'h010, 0, F_W, 0);
    n_checks++; if (rd_data !== 32'hA5ADBEEF) begin n_err++; $display("FAIL sb_lw data got=%h exp=a5adbeef", rd_data); end
  endtask

  task automatic test_half();
    step(1, 0, 9'h022, 32'h00008001, F_H, 0);
    step(0, 1, 9'h022, 0, F_H, 0);
    n_checks++; if (rd_data !== 32'hFFFF8001) begin n_err++; $display("FAIL lh data got=%h exp=ffff8001", rd_data); end
    step(0, 1, 9'h022, 0, F_HU, 0);
    n_checks++; if (rd_data !== 32'h00008001) begin n_err++; $display("FAIL lhu data got=%h exp=00008001", rd_data); end
    step(0, 1, 9'h020, 0, F_H, 0);
    n_checks++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL lh_low data got=%h exp=0", rd_data); end
  endtask

  task automatic test_misaligned();
    logic [15:0] rc0;
    logic [15:0] wc0;
    rc0 = rd_count;
    wc0 = wr_count;
    step(0, 1, 9'h011, 0, F_W, 0);
    n_checks++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_lw pulse got=%b exp=1", misaligned); end
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL mis_lw valid got=%b exp=0", rd_valid); end
    n_checks++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL mis_lw data got=%h exp=0", rd_data); end
    n_checks++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL mis_lw sticky got=%b exp=1", err_sticky); end
    n_checks++; if (rd_count !== rc0) begin n_err++; $display("FAIL mis_lw rd_count got=%0d exp=%0d", rd_count, rc0); end
    step(0, 0, 0, 0, 0, 0);
    n_checks++; if (misaligned !== 1'b0) begin n_err++; $display("FAIL mis_pulse_len got=%b exp=0", misaligned); end
    n_checks++; if (err_sticky !== 1'b1) begin n_err++; $display("FAIL sticky_hold got=%b exp=1", err_sticky); end
    step(1, 0, 9'h012, 32'h12345678, F_W, 0);
    n_checks++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL mis_sw pulse got=%b exp=1", misaligned); end
    n_checks++; if (wr_count !== wc0) begin n_err++; $display("FAIL mis_sw wr_count got=%0d exp=%0d", wr_count, wc0); end
    step(0, 1, 9'h010, 0, F_W, 0);
    n_checks++; if (rd_data !== 32'hA5ADBEEF) begin n_err++; $display("FAIL mis_sw mem got=%h exp=a5adbeef", rd_data); end
    rc0 = rd_count;
    step(1, 1, 9'h010, 32'h0BADF00D, F_W, 0);
    n_checks++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL wr_rd pulse got=%b exp=1", misaligned); end
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL wr_rd valid got=%b exp=0", rd_valid); end
    n_checks++; if (wr_count !== wc0 || rd_count !== rc0) begin n_err++; $display("FAIL wr_rd counts got=%0d/%0d exp=%0d/%0d", wr_count, rd_count, wc0, rc0); end
    step(0, 1, 9'h004, 0, 3'b011, 0);
    n_checks++; if (misaligned !== 1'b1) begin n_err++; $display("FAIL illegal_f3 pulse got=%b exp=1", misaligned); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) step(1, 0, 9'(4*i), 32'(i+1), F_W, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 9'(4*i), 0, F_W, 0);
      n_checks++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b valid[%0d] got=%b exp=1", i, rd_valid); end
      n_checks++; if (rd_data !== 32'(i+1)) begin n_err++; $display("FAIL b2b data[%0d] got=%h exp=%h", i, rd_data, 32'(i+1)); end
    end
    step(0, 0, 0, 0, 0, 0);
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b idle valid got=%b exp=0", rd_valid); end
    n_checks++; if (rd_data !== 32'd4) begin n_err++; $display("FAIL b2b hold data got=%h exp=4", rd_data); end
  endtask

  task automatic test_reset_override();
    step(0, 1, 9'h010, 0, F_W, 0);
    step(0, 1, 9'h010, 0, F_W, 1);
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_ld valid got=%b exp=0", rd_valid); end
    n_checks++; if (rd_count !== 16'h0 || wr_count !== 16'h0) begin n_err++; $display("FAIL rst_ld counts got=%0d/%0d exp=0/0", wr_count, rd_count); end
    n_checks++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL rst_ld sticky got=%b exp=0", err_sticky); end
    step(0, 0, 0, 0, 0, 0);
    n_checks++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_ld late valid got=%b exp=0", rd_valid); end
    step(1, 0, 9'h040, 32'hCAFEF00D, F_W, 1);
    n_checks++; if (wr_count !== 16'h0) begin n_err++; $display("FAIL rst_sw wr_count got=%0d exp=0", wr_count); end
    step(0, 1, 9'h040, 0, F_W, 0);
    n_checks++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL rst_sw mem got=%h exp=0", rd_data); end
    n_checks++; if (rd_valid !== 1'b1 || rd_count !== 16'd1) begin n_err++; $display("FAIL rst_sw lw valid/rc got=%b/%0d exp=1/1", rd_valid, rd_count); end
  endtask

  task automatic test_random();
    int op;
    logic w, r, rs;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 99);
      w  = (op < 45) || (op >= 95);
      r  = (op >= 45);
      rs = (op == 94);
      step(w, r, 9'($urandom_range(0, 63)), $urandom,
           3'($urandom_range(0, 7)), rs);
      n_checks++;
      if (rd_data !== m_data || rd_valid !== m_valid ||
          misaligned !== m_mis || err_sticky !== m_err ||
          wr_count !== 16'(m_wc) || rd_count !== 16'(m_rc)) begin
        n_err++;
        $display("FAIL rand[%0d] got d=%h v=%b m=%b e=%b wc=%0d rc=%0d exp d=%h v=%b m=%b e=%b wc=%0d rc=%0d",
                 n, rd_data, rd_valid, misaligned, err_sticky, wr_count, rd_count,
                 m_data, m_valid, m_mis, m_err, m_wc, m_rc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mm[i] = 8'h00;
    m_data = 0; m_valid = 0; m_mis = 0; m_err = 0; m_wc = 0; m_rc = 0;
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 128; i++) step(1, 0, 9'(4*i), 32'h0, F_W, 0);
    test_reset();
    test_sw_lw();
    test_byte();
    test_half();
    test_misaligned();
    test_back_to_back();
    test_reset_override();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
